// File: rtl/univ_ff_reg.sv
// univ_ff_reg: bank of WIDTH independent flip-flops, each behaving as a D, T, JK
// or SR flop selected by mode. It also keeps a sticky illegal-SR flag and a
// saturating count of edges on which the register changed.
//
// Ports:
//   clk      - clock, all state updates on rising edge
//   rst      - asynchronous active-high reset
//   en       - update enable (0 holds q)
//   clr      - synchronous clear of q to RST_VAL (beats en)
//   mode     - 00 D, 01 T, 10 JK, 11 SR
//   a        - per-bit D / T / J / S
//   b        - per-bit K (JK) / R (SR), unused in D and T
//   err_clr  - clears sr_err (a coincident set wins)
//   q        - register state
//   qb       - combinational complement of q
//   sr_err   - sticky flag: SR mode saw S=R=1 on some bit
//   chg_cnt  - saturating count of edges where q changed
module univ_ff_reg #(
  parameter int unsigned      WIDTH   = 8,
  parameter int unsigned      CNT_W   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             err_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             sr_err,
  output logic [CNT_W-1:0] chg_cnt
);

  localparam logic [1:0]       MODE_D  = 2'b00;
  localparam logic [1:0]       MODE_T  = 2'b01;
  localparam logic [1:0]       MODE_JK = 2'b10;
  localparam logic [1:0]       MODE_SR = 2'b11;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] q_q, q_d;
  logic             sr_err_q, sr_err_d;
  logic [CNT_W-1:0] chg_cnt_q, chg_cnt_d;
  logic [WIDTH-1:0] q_upd;
  logic             sr_illegal;

  // Per-bit next value for the selected flop personality.
  always_comb begin
    q_upd = q_q;
    case (mode)
      MODE_D:  q_upd = a;
      MODE_T:  q_upd = q_q ^ a;
      // JK: set when J, keep when not K; J=K=1 therefore toggles.
      MODE_JK: q_upd = (a & ~q_q) | (~b & q_q);
      // SR: S-only sets, R-only resets, 00 and the illegal 11 both hold.
      MODE_SR: q_upd = (a & ~b) | (q_q & ~(b & ~a));
      default: q_upd = q_q;
    endcase
  end

  // Next-state selection, error flag and change counter.
  always_comb begin
    q_d        = q_q;
    sr_err_d   = sr_err_q;
    chg_cnt_d  = chg_cnt_q;
    sr_illegal = en && !clr && (mode == MODE_SR) && (|(a & b));

    if (clr) begin
      q_d = RST_VAL;
    end else if (en) begin
      q_d = q_upd;
    end

    // Set has priority over a coincident clear.
    if (sr_illegal) begin
      sr_err_d = 1'b1;
    end else if (err_clr) begin
      sr_err_d = 1'b0;
    end

    if ((q_d != q_q) && (chg_cnt_q != CNT_MAX)) begin
      chg_cnt_d = chg_cnt_q + CNT_W'(1);
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q       <= RST_VAL;
      sr_err_q  <= 1'b0;
      chg_cnt_q <= '0;
    end else begin
      q_q       <= q_d;
      sr_err_q  <= sr_err_d;
      chg_cnt_q <= chg_cnt_d;
    end
  end

  assign q       = q_q;
  assign qb      = ~q_q;
  assign sr_err  = sr_err_q;
  assign chg_cnt = chg_cnt_q;

endmodule

// File: tb/tb_univ_ff_reg.sv
// Directed testbench for univ_ff_reg (WIDTH=4, CNT_W=3, RST_VAL=0).
module tb_univ_ff_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       clr;
  logic [1:0] mode;
  logic [3:0] a;
  logic [3:0] b;
  logic       err_clr;
  logic [3:0] q;
  logic [3:0] qb;
  logic       sr_err;
  logic [2:0] chg_cnt;

  int n_cmp = 0;
  int n_err = 0;

  univ_ff_reg #(
    .WIDTH  (4),
    .CNT_W  (3),
    .RST_VAL(4'b0000)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .clr    (clr),
    .mode   (mode),
    .a      (a),
    .b      (b),
    .err_clr(err_clr),
    .q      (q),
    .qb     (qb),
    .sr_err (sr_err),
    .chg_cnt(chg_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic c, input logic [1:0] m,
                       input logic [3:0] av, input logic [3:0] bv, input logic ec);
    en = e; clr = c; mode = m; a = av; b = bv; err_clr = ec;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 2'b00, 4'h0, 4'h0, 1'b0);
    tick();
    check("rst_q", 32'(q), 32'h0);
    check("rst_qb", 32'(qb), 32'hF);
    check("rst_err", 32'(sr_err), 32'h0);
    check("rst_cnt", 32'(chg_cnt), 32'h0);
    rst = 1'b0;

    // D mode
    drive(1'b1, 1'b0, 2'b00, 4'b1010, 4'h0, 1'b0);
    tick();
    check("d_q", 32'(q), 32'hA);
    check("d_qb", 32'(qb), 32'h5);
    check("d_cnt", 32'(chg_cnt), 32'h1);
    tick();
    check("d_same_cnt", 32'(chg_cnt), 32'h1);

    // T mode: 1010 ^ 0110 = 1100
    drive(1'b1, 1'b0, 2'b01, 4'b0110, 4'h0, 1'b0);
    tick();
    check("t_q", 32'(q), 32'hC);
    check("t_cnt", 32'(chg_cnt), 32'h2);

    // Clear to 0000, then JK a=1100 b=1010 -> 1100
    drive(1'b1, 1'b1, 2'b00, 4'hF, 4'h0, 1'b0);
    tick();
    check("clr_q", 32'(q), 32'h0);
    check("clr_cnt", 32'(chg_cnt), 32'h3);
    drive(1'b1, 1'b0, 2'b10, 4'b1100, 4'b1010, 1'b0);
    tick();
    check("jk_q", 32'(q), 32'hC);
    check("jk_cnt", 32'(chg_cnt), 32'h4);
    check("jk_err", 32'(sr_err), 32'h0);

    // Load 0011, then SR a=1001 b=0101: bit3 set, bit2 reset, bit1 hold, bit0 illegal hold
    drive(1'b1, 1'b0, 2'b00, 4'b0011, 4'h0, 1'b0);
    tick();
    check("ld_q", 32'(q), 32'h3);
    drive(1'b1, 1'b0, 2'b11, 4'b1001, 4'b0101, 1'b0);
    tick();
    check("sr_ill_q", 32'(q), 32'hB);
    check("sr_ill_err", 32'(sr_err), 32'h1);
    check("sr_ill_cnt", 32'(chg_cnt), 32'h6);

    // Legal SR with err_clr: 1011 -> set bit2, reset bit0 -> 1110; flag clears
    drive(1'b1, 1'b0, 2'b11, 4'b0100, 4'b0001, 1'b1);
    tick();
    check("sr_leg_q", 32'(q), 32'hE);
    check("sr_leg_err", 32'(sr_err), 32'h0);
    check("sr_leg_cnt", 32'(chg_cnt), 32'h7);

    // Illegal SR with err_clr: set wins, q holds
    drive(1'b1, 1'b0, 2'b11, 4'b0010, 4'b0010, 1'b1);
    tick();
    check("sr_setwin_err", 32'(sr_err), 32'h1);
    check("sr_setwin_q", 32'(q), 32'hE);

    // Async reset between edges
    #2;
    rst = 1'b1;
    #1;
    check("arst_q", 32'(q), 32'h0);
    check("arst_qb", 32'(qb), 32'hF);
    check("arst_err", 32'(sr_err), 32'h0);
    check("arst_cnt", 32'(chg_cnt), 32'h0);
    drive(1'b1, 1'b0, 2'b00, 4'hF, 4'h0, 1'b0);
    tick();
    check("rst_hold_q", 32'(q), 32'h0);
    check("rst_hold_cnt", 32'(chg_cnt), 32'h0);
    rst = 1'b0;
    tick();
    check("post_rst_q", 32'(q), 32'hF);
    check("post_rst_cnt", 32'(chg_cnt), 32'h1);

    // Hold with en=0, illegal SR inputs must not set sr_err
    drive(1'b0, 1'b0, 2'b11, 4'hF, 4'hF, 1'b0);
    tick();
    check("hold_sr_q", 32'(q), 32'hF);
    check("hold_sr_cnt", 32'(chg_cnt), 32'h1);
    check("hold_sr_err", 32'(sr_err), 32'h0);
    drive(1'b0, 1'b0, 2'b00, 4'h0, 4'h0, 1'b0);
    tick();
    check("hold_d_q", 32'(q), 32'hF);

    // Clear with en=0 counts as a change
    drive(1'b0, 1'b1, 2'b00, 4'h0, 4'h0, 1'b0);
    tick();
    check("clr_en0_q", 32'(q), 32'h0);
    check("clr_en0_cnt", 32'(chg_cnt), 32'h2);

    // Clear with en=1 and illegal SR inputs: no error, no change
    drive(1'b1, 1'b1, 2'b11, 4'hF, 4'hF, 1'b0);
    tick();
    check("clr_sr_err", 32'(sr_err), 32'h0);
    check("clr_sr_cnt", 32'(chg_cnt), 32'h2);

    // Saturation: toggle bit0 for 10 edges, count 2 -> 7 and stays
    drive(1'b1, 1'b0, 2'b01, 4'b0001, 4'h0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 2) check("sat_mid_cnt", 32'(chg_cnt), 32'h5);
    end
    check("sat_cnt", 32'(chg_cnt), 32'h7);
    check("sat_q", 32'(q), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
